// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register interface: access direction, response status
// and the host bridge FSM state.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  localparam int RGGEN_STATUS_WIDTH = 2;

  typedef enum logic [RGGEN_STATUS_WIDTH-1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RGGEN_HOST_IDLE    = 2'b00,
    RGGEN_HOST_ACCESS  = 2'b01,
    RGGEN_HOST_RESPOND = 2'b10
  } rggen_host_state_e;

endpackage

// File: rtl/rggen_register_if.sv
// Host-to-register bundle: the bridge drives the command, each register instance
// answers with select/ready/read_data/status.
interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
) ();
  import rggen_rtl_pkg::*;

  logic                     request;
  logic [ADDRESS_WIDTH-1:0] address;
  rggen_direction           direction;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH-1:0]     write_mask;
  logic                     select;
  logic                     ready;
  logic [BUS_WIDTH-1:0]     read_data;
  rggen_status              status;

  modport master (
    output request, address, direction, write_data, write_mask,
    input  select, ready, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_mask,
    output select, ready, read_data, status
  );
endinterface

// File: rtl/rggen_register_response_mux.sv
// Combines the per-register responses into one: selection flags plus the
// ready/read_data/status of the selected register (OR of all selected ones).
module rggen_register_response_mux
  import rggen_rtl_pkg::*;
#(
  parameter int TOTAL_REGISTERS = 1,
  parameter int DATA_WIDTH      = 32
) (
  input  logic [TOTAL_REGISTERS-1:0]                         select,
  input  logic [TOTAL_REGISTERS-1:0]                         ready,
  input  logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0]         read_data,
  input  logic [TOTAL_REGISTERS-1:0][RGGEN_STATUS_WIDTH-1:0] status,
  output logic                                               any_select,
  output logic                                               multi_select,
  output logic                                               selected_ready,
  output logic [DATA_WIDTH-1:0]                              selected_read_data,
  output rggen_status                                        selected_status
);

  logic [RGGEN_STATUS_WIDTH-1:0] status_s;

  // Select-gated OR reduction; a second hit after any earlier one flags a multi-select.
  always_comb begin
    any_select         = 1'b0;
    multi_select       = 1'b0;
    selected_ready     = 1'b0;
    selected_read_data = '0;
    status_s           = '0;
    for (int i = 0; i < TOTAL_REGISTERS; i++) begin
      multi_select       = multi_select | (any_select & select[i]);
      any_select         = any_select | select[i];
      selected_ready     = selected_ready | (select[i] & ready[i]);
      selected_read_data = selected_read_data | ({DATA_WIDTH{select[i]}} & read_data[i]);
      status_s           = status_s | ({RGGEN_STATUS_WIDTH{select[i]}} & status[i]);
    end
    selected_status = rggen_status'(status_s);
  end

endmodule

// File: rtl/rggen_apb_host_bridge.sv
// APB3 target that sequences one register access per transfer across a register
// block, with decode-miss/multi-hit/timeout errors and fully registered responses.
module rggen_apb_host_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic                      i_pwrite,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
  output logic                      o_pready,
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pslverr,
  rggen_register_if.master          register_if [TOTAL_REGISTERS]
);

  localparam int  COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit  TIMEOUT_ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VALUE = COUNT_WIDTH'(TIMEOUT_CYCLES);

  rggen_host_state_e        state_r;
  rggen_host_state_e        state_next_s;
  logic [COUNT_WIDTH-1:0]   count_r;
  logic                     request_r;
  logic [ADDRESS_WIDTH-1:0] address_r;
  rggen_direction           direction_r;
  logic [DATA_WIDTH-1:0]    write_data_r;
  logic [DATA_WIDTH-1:0]    write_mask_r;
  logic                     pready_r;
  logic [DATA_WIDTH-1:0]    prdata_r;
  logic                     pslverr_r;

  logic [DATA_WIDTH-1:0]    mask_s;
  logic                     setup_s;
  logic                     error_s;
  logic                     timeout_s;

  logic [TOTAL_REGISTERS-1:0]                         select_s;
  logic [TOTAL_REGISTERS-1:0]                         ready_s;
  logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0]         read_data_s;
  logic [TOTAL_REGISTERS-1:0][RGGEN_STATUS_WIDTH-1:0] status_s;
  logic                                               any_select_s;
  logic                                               multi_select_s;
  logic                                               mux_ready_s;
  logic [DATA_WIDTH-1:0]                              mux_read_data_s;
  rggen_status                                        mux_status_s;

  for (genvar g = 0; g < TOTAL_REGISTERS; g++) begin : g_register
    assign register_if[g].request    = request_r;
    assign register_if[g].address    = address_r;
    assign register_if[g].direction  = direction_r;
    assign register_if[g].write_data = write_data_r;
    assign register_if[g].write_mask = write_mask_r;
    assign select_s[g]               = register_if[g].select;
    assign ready_s[g]                = register_if[g].ready;
    assign read_data_s[g]            = register_if[g].read_data;
    assign status_s[g]               = register_if[g].status;
  end

  rggen_register_response_mux #(
    .TOTAL_REGISTERS (TOTAL_REGISTERS),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_response_mux (
    .select             (select_s),
    .ready              (ready_s),
    .read_data          (read_data_s),
    .status             (status_s),
    .any_select         (any_select_s),
    .multi_select       (multi_select_s),
    .selected_ready     (mux_ready_s),
    .selected_read_data (mux_read_data_s),
    .selected_status    (mux_status_s)
  );

  assign setup_s   = i_psel & ~i_penable;
  assign timeout_s = TIMEOUT_ENABLED & (count_r == TIMEOUT_VALUE);

  // Byte strobes widened to a bit mask for the write command.
  always_comb begin
    mask_s = '0;
    for (int k = 0; k < DATA_WIDTH / 8; k++) begin
      mask_s[8*k +: 8] = {8{i_pstrb[k]}};
    end
  end

  // Next-state decode; error_s marks a bridge-detected failure on the way to RESPOND.
  always_comb begin
    state_next_s = state_r;
    error_s      = 1'b0;
    case (state_r)
      RGGEN_HOST_IDLE: begin
        if (setup_s) begin
          state_next_s = RGGEN_HOST_ACCESS;
        end else begin
          state_next_s = RGGEN_HOST_IDLE;
        end
      end
      RGGEN_HOST_ACCESS: begin
        if (!i_psel) begin
          state_next_s = RGGEN_HOST_IDLE;
        end else if (!any_select_s || multi_select_s) begin
          state_next_s = RGGEN_HOST_RESPOND;
          error_s      = 1'b1;
        end else if (mux_ready_s) begin
          state_next_s = RGGEN_HOST_RESPOND;
        end else if (timeout_s) begin
          state_next_s = RGGEN_HOST_RESPOND;
          error_s      = 1'b1;
        end else begin
          state_next_s = RGGEN_HOST_ACCESS;
        end
      end
      RGGEN_HOST_RESPOND: state_next_s = RGGEN_HOST_IDLE;
      default:            state_next_s = RGGEN_HOST_IDLE;
    endcase
  end

  // State, command latches, wait counter and the registered APB response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= RGGEN_HOST_IDLE;
      count_r      <= '0;
      request_r    <= 1'b0;
      address_r    <= '0;
      direction_r  <= RGGEN_READ;
      write_data_r <= '0;
      write_mask_r <= '0;
      pready_r     <= 1'b0;
      prdata_r     <= '0;
      pslverr_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      request_r <= (state_next_s == RGGEN_HOST_ACCESS);
      pready_r  <= (state_next_s == RGGEN_HOST_RESPOND);
      if (state_r == RGGEN_HOST_IDLE && setup_s) begin
        count_r      <= '0;
        address_r    <= i_paddr;
        direction_r  <= i_pwrite ? RGGEN_WRITE : RGGEN_READ;
        write_data_r <= i_pwdata;
        write_mask_r <= i_pwrite ? mask_s : '0;
      end else if (TIMEOUT_ENABLED && state_r == RGGEN_HOST_ACCESS &&
                   state_next_s == RGGEN_HOST_ACCESS) begin
        count_r <= count_r + COUNT_WIDTH'(1);
      end else begin
        count_r <= count_r;
      end
      // Only a completing ACCESS updates the held response; writes and errors return zero data.
      if (state_r == RGGEN_HOST_ACCESS && state_next_s == RGGEN_HOST_RESPOND) begin
        prdata_r  <= (error_s || direction_r == RGGEN_WRITE) ? '0 : mux_read_data_s;
        pslverr_r <= error_s || (mux_status_s != RGGEN_OKAY);
      end else begin
        prdata_r  <= prdata_r;
        pslverr_r <= pslverr_r;
      end
    end
  end

  assign o_pready  = pready_r;
  assign o_prdata  = prdata_r;
  assign o_pslverr = pslverr_r;

endmodule
